// File: rtl/sram_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl_if
//   Ready/valid handshake bundle between a producer/consumer pair and the
//   SRAM-backed FIFO controller.
//
//   Signals
//     enq_valid  producer has data
//     enq_ready  controller accepts data this cycle
//     enq_bits   enqueue data (WIDTH)
//     deq_valid  head entry valid
//     deq_ready  consumer takes head
//     deq_bits   head data (WIDTH)
//     count      total entries held by the controller (CW)
//
//   Modports
//     master  producer/consumer side (drives enq_valid, enq_bits, deq_ready)
//     slave   controller side
// -----------------------------------------------------------------------------
interface sram_fifo_ctrl_if #(
    parameter int WIDTH = 64,
    parameter int CW    = 6
);
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_bits;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_bits;
    logic [CW-1:0]    count;

    modport master (
        output enq_valid, enq_bits, deq_ready,
        input  enq_ready, deq_valid, deq_bits, count
    );

    modport slave (
        input  enq_valid, enq_bits, deq_ready,
        output enq_ready, deq_valid, deq_bits, count
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
//   Turns one 1R1W synchronous SRAM macro (active-low chip selects, registered
//   read with one cycle of latency) into a ready/valid FIFO. The controller owns
//   the read/write pointers and hides the read latency behind a two-entry
//   output buffer so that one enqueue and one dequeue can complete every cycle.
//   Total capacity is DEPTH + 2 entries (SRAM plus output buffer).
//
//   Ports
//     clock      single clock (also clocks the macro CE1/CE2)
//     reset      synchronous, active-high
//     io         sram_fifo_ctrl_if.slave: enq/deq handshakes and count
//     sram_a1    read address
//     sram_csb1  read chip select, active-low
//     sram_oeb1  output enable, tied low
//     sram_o1    read data, valid the cycle after a read is issued
//     sram_a2    write address
//     sram_csb2  write chip select, active-low
//     sram_web2  write enable, active-low
//     sram_i2    write data
//
//   Build option
//     FIFO_BYPASS_EN  when defined, an enqueue that arrives while the SRAM path
//                     is empty is written straight into the output buffer,
//                     cutting empty-to-valid latency from 2 cycles to 1.
// -----------------------------------------------------------------------------
module sram_fifo_ctrl #(
    parameter int DEPTH = 25,
    parameter int WIDTH = 64,
    parameter int AW    = 5,
    parameter int CW    = 6
) (
    input  logic              clock,
    input  logic              reset,
    sram_fifo_ctrl_if.slave   io,
    output logic [AW-1:0]     sram_a1,
    output logic              sram_csb1,
    output logic              sram_oeb1,
    input  logic [WIDTH-1:0]  sram_o1,
    output logic [AW-1:0]     sram_a2,
    output logic              sram_csb2,
    output logic              sram_web2,
    output logic [WIDTH-1:0]  sram_i2
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [AW-1:0]    wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0]    mem_occ_q,    mem_occ_d;    // entries resident in SRAM
    logic             inflight_q,   inflight_d;   // read issued last cycle
    logic [1:0]       outbuf_cnt_q, outbuf_cnt_d;
    logic [WIDTH-1:0] outbuf_q [2];
    logic [WIDTH-1:0] outbuf_d [2];

    // -------------------------------------------------------------------------
    // Handshake and control decode
    // -------------------------------------------------------------------------
    logic       enq_ready;
    logic       deq_valid;
    logic       enq_fire;
    logic       deq_fire;
    logic       bypass;
    logic       sram_wr;
    logic       rd_issue;
    logic [2:0] lane_occ;     // outbuf entries plus a read still in flight
    logic [2:0] lane_limit;   // room in the two-entry lane after this cycle's pop

    // Only SRAM occupancy gates the producer, so there is no combinational
    // path from deq_ready to enq_ready.
    assign enq_ready = !reset && (mem_occ_q < CW'(DEPTH));

    // Returning read data falls through to the head in the cycle it arrives,
    // so the head is valid while either the buffer or the return lane holds it.
    assign deq_valid = !reset && ((outbuf_cnt_q != 2'd0) || inflight_q);

    assign enq_fire   = io.enq_valid && enq_ready;
    assign deq_fire   = deq_valid && io.deq_ready;

    assign lane_occ   = 3'(outbuf_cnt_q) + 3'(inflight_q);
    assign lane_limit = 3'd2 + 3'(deq_fire);

`ifdef FIFO_BYPASS_EN
    // Bypass only when nothing older sits in SRAM or in flight; otherwise the
    // new entry would overtake them.
    assign bypass = enq_fire && (mem_occ_q == '0) && !inflight_q &&
                    (3'(outbuf_cnt_q) < lane_limit);
`else
    assign bypass = 1'b0;
`endif

    assign sram_wr  = enq_fire && !bypass;

    // An entry written on this edge is not counted in mem_occ_q until the
    // next cycle, so a read never targets a same-edge write.
    assign rd_issue = !reset && (mem_occ_q != '0) && (lane_occ < lane_limit);

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign io.enq_ready = enq_ready;
    assign io.deq_valid = deq_valid;
    assign io.deq_bits  = (outbuf_cnt_q != 2'd0) ? outbuf_q[0] : sram_o1;
    assign io.count     = reset ? '0
                                : mem_occ_q + CW'(inflight_q) + CW'(outbuf_cnt_q);

    assign sram_a1   = rd_ptr_q;
    assign sram_csb1 = !rd_issue;
    assign sram_oeb1 = 1'b0;
    assign sram_a2   = wr_ptr_q;
    assign sram_csb2 = !sram_wr;
    assign sram_web2 = !sram_wr;
    assign sram_i2   = io.enq_bits;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // Explicit compare so the wrap point is DEPTH-1 even when DEPTH is not a
    // power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_occ_d    = mem_occ_q;
        inflight_d   = rd_issue;
        outbuf_d     = outbuf_q;
        outbuf_cnt_d = outbuf_cnt_q;

        if (sram_wr) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_issue) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // The slot is released at issue; the macro returns the old data even
        // if the same slot is rewritten on this edge.
        mem_occ_d = mem_occ_q + CW'(sram_wr) - CW'(rd_issue);

        // The lane is updated in arrival order: append the return behind any
        // buffered entry, pop the head, then append a bypassed entry. Later
        // steps read the results of earlier ones, which is why these are
        // blocking assignments inside one combinational block.
        if (inflight_q) begin
            if (outbuf_cnt_d == 2'd0) begin
                outbuf_d[0] = sram_o1;
            end else begin
                outbuf_d[1] = sram_o1;
            end
            outbuf_cnt_d = outbuf_cnt_d + 2'd1;
        end
        if (deq_fire) begin
            outbuf_d[0]  = outbuf_d[1];
            outbuf_cnt_d = outbuf_cnt_d - 2'd1;
        end
        if (bypass) begin
            if (outbuf_cnt_d == 2'd0) begin
                outbuf_d[0] = io.enq_bits;
            end else begin
                outbuf_d[1] = io.enq_bits;
            end
            outbuf_cnt_d = outbuf_cnt_d + 2'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_occ_q    <= '0;
            inflight_q   <= 1'b0;   // drops a read in flight; its data is ignored
            outbuf_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_occ_q    <= mem_occ_d;
            inflight_q   <= inflight_d;
            outbuf_cnt_q <= outbuf_cnt_d;
        end
    end

    // NOTE: buffer payload is not reset; outbuf_cnt_q alone decides which
    // entries are meaningful, so clearing the data would only add reset fanout.
    always_ff @(posedge clock) begin
        outbuf_q <= outbuf_d;
    end

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    a_lane_bound : assert property (@(posedge clock) disable iff (reset)
        (3'(outbuf_cnt_q) + 3'(inflight_q)) <= 3'd2);

    a_mem_bound : assert property (@(posedge clock) disable iff (reset)
        mem_occ_q <= CW'(DEPTH));

    a_ptr_range : assert property (@(posedge clock) disable iff (reset)
        (wr_ptr_q < AW'(DEPTH)) && (rd_ptr_q < AW'(DEPTH)));

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_fifo_ctrl
//   Self-checking bench for sram_fifo_ctrl with a behavioural 1R1W SRAM model.
//   Accepted enqueues are pushed into a scoreboard queue; every dequeue pops
//   and compares. The count output is compared against the scoreboard depth
//   every cycle, and stalled heads must hold their data.
// -----------------------------------------------------------------------------
module tb_sram_fifo_ctrl;

    localparam int DEPTH = 25;
    localparam int WIDTH = 64;
    localparam int AW    = 5;
    localparam int CW    = 6;

`ifdef FIFO_BYPASS_EN
    localparam int EXP_LAT   = 1;
    localparam int MIN_WRAPS = 1;
`else
    localparam int EXP_LAT   = 2;
    localparam int MIN_WRAPS = 2;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic [AW-1:0]    sram_a1;
    logic             sram_csb1;
    logic             sram_oeb1;
    logic [WIDTH-1:0] sram_o1 = '0;
    logic [AW-1:0]    sram_a2;
    logic             sram_csb2;
    logic             sram_web2;
    logic [WIDTH-1:0] sram_i2;

    sram_fifo_ctrl_if #(.WIDTH(WIDTH), .CW(CW)) io ();

    sram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .CW(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .io        (io),
        .sram_a1   (sram_a1),
        .sram_csb1 (sram_csb1),
        .sram_oeb1 (sram_oeb1),
        .sram_o1   (sram_o1),
        .sram_a2   (sram_a2),
        .sram_csb2 (sram_csb2),
        .sram_web2 (sram_web2),
        .sram_i2   (sram_i2)
    );

    always #5 clock = ~clock;

    // Behavioural macro: registered read returns pre-edge contents.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (!sram_csb1) begin
            sram_o1 <= (int'(sram_a1) < DEPTH) ? mem[sram_a1] : 64'hDEAD_BEEF_DEAD_BEEF;
        end
        if (!sram_csb2 && !sram_web2 && (int'(sram_a2) < DEPTH)) begin
            mem[sram_a2] <= sram_i2;
        end
    end

    // -------------------------------------------------------------------------
    // Checking and scoreboard state
    // -------------------------------------------------------------------------
    int               n_checks = 0;
    int               n_errors = 0;
    logic [WIDTH-1:0] exp_q [$];
    int               cyc = 0;
    logic             enq_fired;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_bits;
    int               deq_total = 0;
    int               first_deq = -1;
    int               last_deq  = -1;
    int               last_wa = -1, last_ra = -1;
    int               wr_wraps = 0, rd_wraps = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Samples outputs mid-cycle and updates the scoreboard.
    task automatic observe();
        enq_fired = 1'b0;
        if (reset) begin
            prev_stall = 1'b0;
            return;
        end
        check("count", 64'(io.count), 64'(exp_q.size()));
        if (prev_stall) begin
            check("hold_valid", 64'(io.deq_valid), 64'd1);
            check("hold_bits", io.deq_bits, prev_bits);
        end
        if (!sram_csb1) begin
            check("a1_range", 64'(int'(sram_a1) < DEPTH), 64'd1);
            if (int'(sram_a1) == 0 && last_ra == DEPTH - 1) rd_wraps++;
            last_ra = int'(sram_a1);
        end
        if (!sram_csb2 && !sram_web2) begin
            check("a2_range", 64'(int'(sram_a2) < DEPTH), 64'd1);
            if (int'(sram_a2) == 0 && last_wa == DEPTH - 1) wr_wraps++;
            last_wa = int'(sram_a2);
        end
        if (io.deq_valid && io.deq_ready) begin
            if (exp_q.size() == 0) check("deq_extra", 64'd1, 64'd0);
            else check("deq_data", io.deq_bits, exp_q.pop_front());
            deq_total++;
            if (first_deq < 0) first_deq = cyc;
            last_deq = cyc;
        end
        if (io.enq_valid && io.enq_ready) begin
            exp_q.push_back(io.enq_bits);
            enq_fired = 1'b1;
        end
        prev_stall = io.deq_valid && !io.deq_ready;
        prev_bits  = io.deq_bits;
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later.
    task automatic cycle(input logic ev, input logic [WIDTH-1:0] eb, input logic dr);
        @(negedge clock);
        io.enq_valid = ev;
        io.enq_bits  = eb;
        io.deq_ready = dr;
        cyc++;
        #1;
        observe();
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        reset        = 1'b1;
        io.enq_valid = 1'b0;
        io.enq_bits  = '0;
        io.deq_ready = 1'b0;
        #1;
        check("rst_enq_ready", 64'(io.enq_ready), 64'd0);
        check("rst_deq_valid", 64'(io.deq_valid), 64'd0);
        check("rst_count", 64'(io.count), 64'd0);
        check("rst_csb1", 64'(sram_csb1), 64'd1);
        check("rst_csb2", 64'(sram_csb2), 64'd1);
        check("rst_web2", 64'(sram_web2), 64'd1);
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        prev_stall = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            cycle(1'b0, '0, 1'b1);
            b--;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic push_val(input logic [WIDTH-1:0] v, input logic dr);
        int b = 50;
        enq_fired = 1'b0;
        while (!enq_fired && b > 0) begin
            cycle(1'b1, v, dr);
            b--;
        end
        if (!enq_fired) check("enq_timeout", 64'd0, 64'd1);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int lat;
        int acc;
        int sent;
        int w0, r0;
        io.enq_valid = 1'b0;
        io.enq_bits  = '0;
        io.deq_ready = 1'b0;
        reset        = 1'b1;

        do_reset(2);

        // Empty-to-valid latency with a single entry.
        cycle(1'b1, 64'hA5, 1'b1);
        check("t1_enq_ready", 64'(enq_fired), 64'd1);
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, '0, 1'b1);
            if (io.deq_valid) begin
                lat = k;
                break;
            end
        end
        check("t1_latency", 64'(lat), 64'(EXP_LAT));
        cycle(1'b0, '0, 1'b1);
        check("t1_count", 64'(io.count), 64'd0);

        // Fill to capacity with the consumer stalled, then drain in order.
        acc = 0;
        for (int k = 0; k < 80 && acc < DEPTH + 2; k++) begin
            cycle(1'b1, 64'(acc), 1'b0);
            if (enq_fired) acc++;
        end
        check("t2_accepted", 64'(acc), 64'(DEPTH + 2));
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 64'h99, 1'b0);
            check("t2_full_ready", 64'(io.enq_ready), 64'd0);
        end
        check("t2_full_count", 64'(io.count), 64'(DEPTH + 2));
        drain("t2_drain", 60);

        // Streaming: one enq and one deq per cycle without bubbles.
        first_deq = -1;
        deq_total = 0;
        acc = 0;
        for (int i = 1; i <= 100; i++) begin
            cycle(1'b1, 64'(i), 1'b1);
            if (enq_fired) acc++;
        end
        drain("t3_drain", 20);
        check("t3_accepted", 64'(acc), 64'd100);
        check("t3_deqs", 64'(deq_total), 64'd100);
        check("t3_no_bubbles", 64'(last_deq - first_deq), 64'd99);

        // Bursts of 7 to walk the pointers around the wrap point.
        w0 = wr_wraps;
        r0 = rd_wraps;
        sent = 0;
        while (sent < 60) begin
            for (int j = 0; j < 7 && sent < 60; j++) begin
                push_val(64'h4000 + 64'(sent), 1'b0);
                sent++;
            end
            drain("t4_drain", 30);
        end
        check("t4_wr_wraps", 64'(wr_wraps - w0 >= MIN_WRAPS), 64'd1);
        check("t4_rd_wraps", 64'(rd_wraps - r0 >= MIN_WRAPS), 64'd1);

        // Random producer and 50% consumer stalls.
        for (int k = 0; k < 300; k++) begin
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        drain("t5_drain", 80);

        // Reset with a read in flight and ten entries held.
        for (int i = 0; i < 10; i++) push_val(64'h100 + 64'(i), 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 64'h200, 1'b1);
        check("t6_issue", 64'(sram_csb1), 64'd0);
        do_reset(1);
        cycle(1'b0, '0, 1'b0);
        check("t6_count", 64'(io.count), 64'd0);
        check("t6_deq_valid", 64'(io.deq_valid), 64'd0);
        check("t6_csb1", 64'(sram_csb1), 64'd1);
        check("t6_csb2", 64'(sram_csb2), 64'd1);
        check("t6_ready", 64'(io.enq_ready), 64'd1);
        cycle(1'b0, '0, 1'b1);
        check("t6_stale", 64'(io.deq_valid), 64'd0);
        cycle(1'b1, 64'h77, 1'b1);
        drain("t6_drain", 10);
        check("t6_deq_after", 64'(last_deq > 0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
